// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants.
// Used by the write scheduler and its pixel producers.
package fb_pkg;

  localparam int FB_COORD_W = 6;
  localparam int FB_COLOR_W = 12;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic [FB_COORD_W-1:0] x;
    logic [FB_COORD_W-1:0] y;
    logic [FB_COLOR_W-1:0] color;
  } fb_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from ptr upward.
// The pointer moves past the winner on each advance strobe.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  valid,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] cand;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        winner      = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // pointer moves to the slot after the winner
  always_comb begin
    ptr_d = ptr_q;
    if (advance && any) begin
      if (winner == PW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + PW'(1);
      end
    end
  end

  // pointer register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: clear sweep plus
// round-robin sharing of the port among pixel producers.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int COORD_W = FB_COORD_W,
  parameter int COLOR_W = FB_COLOR_W,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*COORD_W-1:0]   req_x,
  input  logic [NUM_REQ*COORD_W-1:0]   req_y,
  input  logic [NUM_REQ*COLOR_W-1:0]   req_color,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         fb_we,
  output logic [COORD_W-1:0]           fb_x,
  output logic [COORD_W-1:0]           fb_y,
  output logic [COLOR_W-1:0]           fb_color,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = 2 * COORD_W;

  fb_state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               fb_we_q, fb_we_d;
  logic [COORD_W-1:0] fb_x_q, fb_x_d;
  logic [COORD_W-1:0] fb_y_q, fb_y_d;
  logic [COLOR_W-1:0] fb_color_q, fb_color_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;

  logic [COORD_W-1:0] x_arr [NUM_REQ];
  logic [COORD_W-1:0] y_arr [NUM_REQ];
  logic [COLOR_W-1:0] c_arr [NUM_REQ];

  logic               can_grant;
  logic [NUM_REQ-1:0] valid_m;
  logic [NUM_REQ-1:0] arb_grant;
  logic [GW-1:0]      arb_winner;
  logic               arb_any;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign x_arr[i] = req_x[i*COORD_W +: COORD_W];
    assign y_arr[i] = req_y[i*COORD_W +: COORD_W];
    assign c_arr[i] = req_color[i*COLOR_W +: COLOR_W];
  end

  // clear_start pre-empts any grant in the cycle it is seen
  assign can_grant = (state_q == RUN) && !clear_start;
  assign valid_m   = req_valid & {NUM_REQ{can_grant}};

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .valid   (valid_m),
    .advance (arb_any),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .any     (arb_any)
  );

  // next state, sweep counter and output register loads
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fb_we_d    = 1'b0;
    fb_x_d     = fb_x_q;
    fb_y_d     = fb_y_q;
    fb_color_d = fb_color_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      CLEAR: begin
        fb_we_d    = 1'b1;
        fb_x_d     = cnt_q[COORD_W-1:0];
        fb_y_d     = cnt_q[CW-1:COORD_W];
        fb_color_d = CLEAR_COLOR;
        cnt_d      = cnt_q + CW'(1);
        if (&cnt_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clear_start) begin
          state_d = CLEAR;
        end else if (arb_any) begin
          fb_we_d    = 1'b1;
          fb_x_d     = x_arr[arb_winner];
          fb_y_d     = y_arr[arb_winner];
          fb_color_d = c_arr[arb_winner];
          grant_id_d = arb_winner;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // state, sweep counter and registered write port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      fb_we_q    <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_color_q <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fb_we_q    <= fb_we_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      fb_color_q <= fb_color_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign req_ready  = arb_grant;
  assign clear_busy = (state_q == CLEAR);
  assign fb_we      = fb_we_q;
  assign fb_x       = fb_x_q;
  assign fb_y       = fb_y_q;
  assign fb_color   = fb_color_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: sweep order, arbitration
// against a queue-free round-robin model, clear and reset.
module tb_fb_write_scheduler;

  localparam int N = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*6-1:0]  req_x;
  logic [N*6-1:0]  req_y;
  logic [N*12-1:0] req_color;
  logic            clear_start;
  logic            clear_busy;
  logic            fb_we;
  logic [5:0]      fb_x;
  logic [5:0]      fb_y;
  logic [11:0]     fb_color;
  logic [1:0]      grant_id;

  logic [5:0]  rx [N];
  logic [5:0]  ry [N];
  logic [11:0] rc [N];

  assign req_x     = {rx[2], rx[1], rx[0]};
  assign req_y     = {ry[2], ry[1], ry[0]};
  assign req_color = {rc[2], rc[1], rc[0]};

  fb_write_scheduler #(
    .NUM_REQ     (N),
    .COORD_W     (6),
    .COLOR_W     (12),
    .CLEAR_COLOR (12'h000)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .fb_we       (fb_we),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_color    (fb_color),
    .grant_id    (grant_id)
  );

  int pass_cnt = 0;
  int total = 0;

  int          ptr;
  logic [5:0]  ex;
  logic [5:0]  ey;
  logic [11:0] ec;
  logic [1:0]  egid;

  task automatic test_reset();
    resetn = 1'b0;
    clear_start = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      rx[2'(i)] = 6'd0;
      ry[2'(i)] = 6'd0;
      rc[2'(i)] = 12'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (fb_we !== 1'b0) $display("FAIL reset_we got %b exp 0", fb_we);
    else pass_cnt++;
    total++;
    if (fb_x !== 6'd0 || fb_y !== 6'd0)
      $display("FAIL reset_xy got %0d,%0d exp 0,0", fb_x, fb_y);
    else pass_cnt++;
    total++;
    if (fb_color !== 12'h000) $display("FAIL reset_color got %h exp 000", fb_color);
    else pass_cnt++;
    total++;
    if (grant_id !== 2'd0) $display("FAIL reset_gid got %0d exp 0", grant_id);
    else pass_cnt++;
    total++;
    if (clear_busy !== 1'b1) $display("FAIL reset_busy got %b exp 1", clear_busy);
    else pass_cnt++;
    total++;
    if (req_ready !== 3'b000) $display("FAIL reset_ready got %b exp 000", req_ready);
    else pass_cnt++;
    req_valid = 3'b000;
    ptr = 0;
    egid = 2'd0;
  endtask

  // checks the first n writes of a sweep, optionally poking clear_start mid-way
  task automatic check_sweep(input int n, input bit poke);
    logic eb;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      clear_start = (poke && i == 2000);
      eb = (i != 4095);
      total++;
      if (fb_we !== 1'b1) $display("FAIL sweep_we i=%0d got %b exp 1", i, fb_we);
      else pass_cnt++;
      total++;
      if (fb_x !== 6'(i % 64) || fb_y !== 6'(i / 64))
        $display("FAIL sweep_addr i=%0d got %0d,%0d exp %0d,%0d",
                 i, fb_x, fb_y, i % 64, i / 64);
      else pass_cnt++;
      total++;
      if (fb_color !== 12'h000) $display("FAIL sweep_color i=%0d got %h exp 000", i, fb_color);
      else pass_cnt++;
      total++;
      if (clear_busy !== eb) $display("FAIL sweep_busy i=%0d got %b exp %b", i, clear_busy, eb);
      else pass_cnt++;
      if (i != 4095) begin
        total++;
        if (req_ready !== 3'b000)
          $display("FAIL sweep_ready i=%0d got %b exp 000", i, req_ready);
        else pass_cnt++;
      end
    end
    clear_start = 1'b0;
    if (n == 4096) begin
      ex = 6'd63;
      ey = 6'd63;
      ec = 12'h000;
    end
  endtask

  // one RUN cycle checked against the round-robin model
  task automatic step(output int w);
    logic [N-1:0] er;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (w < 0 && req_valid[2'(c)]) w = c;
    end
    er = (w >= 0) ? (N'(1) << w) : '0;
    total++;
    if (req_ready !== er) $display("FAIL step_ready got %b exp %b", req_ready, er);
    else pass_cnt++;
    @(posedge clk);
    #1;
    if (w >= 0) begin
      ex = rx[2'(w)];
      ey = ry[2'(w)];
      ec = rc[2'(w)];
      egid = 2'(w);
      ptr = (w + 1) % N;
    end
    total++;
    if (fb_we !== (w >= 0)) $display("FAIL step_we got %b exp %b", fb_we, (w >= 0));
    else pass_cnt++;
    total++;
    if (fb_x !== ex || fb_y !== ey)
      $display("FAIL step_xy got %0d,%0d exp %0d,%0d", fb_x, fb_y, ex, ey);
    else pass_cnt++;
    total++;
    if (fb_color !== ec) $display("FAIL step_color got %h exp %h", fb_color, ec);
    else pass_cnt++;
    total++;
    if (grant_id !== egid) $display("FAIL step_gid got %0d exp %0d", grant_id, egid);
    else pass_cnt++;
    total++;
    if (clear_busy !== 1'b0) $display("FAIL step_busy got %b exp 0", clear_busy);
    else pass_cnt++;
  endtask

  task automatic test_boot_sweep();
    int w;
    resetn = 1'b1;
    check_sweep(4096, 1'b0);
    req_valid = 3'b000;
    step(w);
  endtask

  task automatic test_single();
    int w;
    rx[1] = 6'd5;
    ry[1] = 6'd7;
    rc[1] = 12'hF80;
    req_valid = 3'b010;
    step(w);
    req_valid = 3'b000;
    total++;
    if (fb_x !== 6'd5 || fb_y !== 6'd7 || fb_color !== 12'hF80 || grant_id !== 2'd1)
      $display("FAIL single_write got %0d,%0d,%h,%0d exp 5,7,f80,1",
               fb_x, fb_y, fb_color, grant_id);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int w;
    req_valid = 3'b111;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        rx[2'(i)] = 6'($urandom);
        ry[2'(i)] = 6'($urandom);
        rc[2'(i)] = 12'($urandom);
      end
      step(w);
    end
    req_valid = 3'b000;
  endtask

  task automatic test_ptr_wrap();
    int w;
    req_valid = 3'b001;
    step(w);
    req_valid = 3'b101;
    rx[0] = 6'd11; ry[0] = 6'd12; rc[0] = 12'h0A0;
    rx[2] = 6'd21; ry[2] = 6'd22; rc[2] = 12'h00B;
    step(w);
    req_valid = 3'b001;
    step(w);
    req_valid = 3'b111;
    step(w);
    req_valid = 3'b000;
  endtask

  task automatic test_random();
    int w;
    w = -1;
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[2'(i)] || w == i) begin
          req_valid[2'(i)] = 1'($urandom_range(0, 1));
          rx[2'(i)] = 6'($urandom);
          ry[2'(i)] = 6'($urandom);
          rc[2'(i)] = 12'($urandom);
        end
      end
      step(w);
    end
    req_valid = 3'b000;
  endtask

  task automatic test_clear_start();
    int w;
    rx[0] = 6'd33; ry[0] = 6'd44; rc[0] = 12'h5A5;
    req_valid = 3'b001;
    clear_start = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b000) $display("FAIL clr_ready got %b exp 000", req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    total++;
    if (clear_busy !== 1'b1) $display("FAIL clr_busy_rise got %b exp 1", clear_busy);
    else pass_cnt++;
    total++;
    if (fb_we !== 1'b0) $display("FAIL clr_gap_we got %b exp 0", fb_we);
    else pass_cnt++;
    check_sweep(4096, 1'b1);
    step(w);
    req_valid = 3'b000;
    total++;
    if (grant_id !== 2'd0 || fb_x !== 6'd33)
      $display("FAIL clr_post_grant got gid %0d x %0d exp 0,33", grant_id, fb_x);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w;
    req_valid = 3'b000;
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    check_sweep(1001, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (fb_we !== 1'b0 || clear_busy !== 1'b1)
      $display("FAIL midrst_async got we %b busy %b exp 0,1", fb_we, clear_busy);
    else pass_cnt++;
    total++;
    if (fb_x !== 6'd0 || fb_y !== 6'd0 || fb_color !== 12'h000 || grant_id !== 2'd0)
      $display("FAIL midrst_regs got %0d,%0d,%h,%0d exp 0,0,000,0",
               fb_x, fb_y, fb_color, grant_id);
    else pass_cnt++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    ptr = 0;
    egid = 2'd0;
    check_sweep(4096, 1'b0);
    step(w);
  endtask

  initial begin
    test_reset();
    test_boot_sweep();
    test_single();
    test_contention();
    test_ptr_wrap();
    test_random();
    test_clear_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Single-port framebuffer write scheduler for the 64x64, 12-bit-colour display path. It shares one framebuffer write port among several pixel producers with a round-robin valid/ready arbiter. Producers include the particle scan-out, a cursor/overlay and a debug writer. It also sequences a full-screen clear sweep, which runs automatically after reset and on request. It sits between the producers and the framebuffer RAM write port.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- COORD_W, 6, coordinate width; screen is 2^COORD_W square
- COLOR_W, 12, pixel colour width (RGB444)
- CLEAR_COLOR, 12'h000, colour written by the clear sweep

Ports (reset resetn, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_x  in  NUM_REQ*COORD_W  packed x; requester i at [i*COORD_W +: COORD_W]
- req_y  in  NUM_REQ*COORD_W  packed y, same packing
- req_color  in  NUM_REQ*COLOR_W  packed colour, same packing
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on valid&&ready
- clear_start  in  1  single-cycle request to clear the whole screen
- clear_busy  out  1  high while the sweep is in progress
- fb_we  out  1  framebuffer write enable, registered
- fb_x, fb_y  out  COORD_W  write address, registered
- fb_color  out  COLOR_W  write data, registered
- grant_id  out  $clog2(NUM_REQ)  index of the last requester granted, registered

## Operation
- FSM states: CLEAR and RUN. Reset state is CLEAR.
- CLEAR:
  - A 2*COORD_W-bit sweep counter starts at 0. x is the low half (fastest), y is the high half.
  - Each cycle the output register loads fb_we=1, the counter address and CLEAR_COLOR. The counter then increments.
  - After address (63,63) is loaded, the state goes to RUN and the counter returns to 0.
  - req_ready is all-zero throughout. clear_start is ignored; the sweep is not restarted.
- RUN:
  - If clear_start=1, the state goes to CLEAR next cycle and no grant is issued that cycle. clear_start beats any request.
  - Otherwise a round-robin arbiter grants the first valid requester at or after pointer ptr, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On the next edge the output register loads fb_we=1 with the winner's x/y/color, and grant_id=winner.
  - ptr becomes (winner+1) mod NUM_REQ. With no valid requester, ptr holds, fb_we loads 0, and fb_x/fb_y/fb_color/grant_id hold.
- Requester rule: valid, x, y and color stay stable until ready. The scheduler never drops an accepted transfer.
- ready never depends on a requester's own ready, so there is no combinational loop through the arbiter.

## Timing
- Reset values: fb_we=0, fb_x=0, fb_y=0, fb_color=0, grant_id=0, ptr=0, req_ready=0, clear_busy=1. clear_busy is (state==CLEAR).
- First clear write appears on fb_* at the first clk edge after resetn deasserts.
- A clear sweep is exactly 4096 consecutive fb_we cycles with no gaps.
- clear_busy falls on the same edge that presents the last clear write (63,63).
- A grant is possible in the cycle immediately after that edge, so there is no idle gap after a sweep.
- Grant-to-write latency is 1 cycle. Sustained throughput is 1 write per cycle.
- Under full contention, each of the NUM_REQ requesters is granted exactly once every NUM_REQ cycles.
- clear_start in RUN: one no-grant cycle, then the sweep starts. fb_we for the first clear write appears 2 edges after the clear_start cycle.
- Reset asserted mid-sweep or mid-RUN: all outputs return to reset values immediately (asynchronously), and a full sweep restarts after release.

## Structure
- Shared package fb_pkg:
  - FB_COORD_W=6 and FB_COLOR_W=12
  - fb_state_t enum {CLEAR, RUN}
  - fb_wr_t struct {x, y, color}, reused by producers
- Sub-module rr_arbiter, parameterised on N:
  - combinational one-hot grant from the valid vector and ptr
  - ptr register, advanced by an external advance strobe
- The top level owns the FSM, the sweep counter and the output register.

## Test plan
- Reset release, no requests → fb_we high for 4096 cycles covering (0,0)…(63,63) with colour 000 in x-fastest order; clear_busy falls with the (63,63) write; then fb_we=0.
- After the sweep, only req 1 valid with (5,7,F80) → req_ready=3'b010 in the same cycle; next edge fb_we=1, fb=(5,7), colour F80, grant_id=1.
- All three valid continuously → grants in order 0,1,2,0,1,2 with fb_we high every cycle.
- Req 0 and req 2 valid with ptr=1 → req 2 wins, then req 0, and ptr ends at 1.
- clear_start pulsed while req 0 is valid in RUN → req_ready=0 that cycle; clear_busy rises next edge; 4096 clear writes follow; req 0 is granted in the first cycle after the sweep.
- resetn pulsed low at sweep address 1000 → fb_we=0 and clear_busy=1 immediately; after release the sweep restarts at (0,0).
